// File: rtl/decode_execute_reg.sv
// Decode->Execute pipeline register with stall hold, flush bubble insertion,
// a valid bit and saturating stall/bubble performance counters.
module decode_execute_reg #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int ALUCTL_W = 3,
    parameter int RESSRC_W = 2,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                StallE,
    input  logic                FlushE,
    input  logic                CntClr,
    input  logic                ValidD,
    input  logic                RegWriteD,
    input  logic                MemWriteD,
    input  logic                JumpD,
    input  logic                BranchD,
    input  logic                ALUSrcD,
    input  logic [RESSRC_W-1:0] ResultSrcD,
    input  logic [ALUCTL_W-1:0] ALUControlD,
    input  logic [XLEN-1:0]     RD1D,
    input  logic [XLEN-1:0]     RD2D,
    input  logic [XLEN-1:0]     PCD,
    input  logic [XLEN-1:0]     ExtImmD,
    input  logic [XLEN-1:0]     PCPlus4D,
    input  logic [REG_AW-1:0]   RS1D,
    input  logic [REG_AW-1:0]   RS2D,
    input  logic [REG_AW-1:0]   RDD,
    output logic                ValidE,
    output logic                RegWriteE,
    output logic                MemWriteE,
    output logic                JumpE,
    output logic                BranchE,
    output logic                ALUSrcE,
    output logic [RESSRC_W-1:0] ResultSrcE,
    output logic [ALUCTL_W-1:0] ALUControlE,
    output logic [XLEN-1:0]     RD1E,
    output logic [XLEN-1:0]     RD2E,
    output logic [XLEN-1:0]     PCE,
    output logic [XLEN-1:0]     ExtImmE,
    output logic [XLEN-1:0]     PCPlus4E,
    output logic [REG_AW-1:0]   RS1E,
    output logic [REG_AW-1:0]   RS2E,
    output logic [REG_AW-1:0]   RDE,
    output logic [CNT_W-1:0]    StallCount,
    output logic [CNT_W-1:0]    BubbleCount
);

    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic                mem_write;
        logic                jump;
        logic                branch;
        logic                alu_src;
        logic [RESSRC_W-1:0] result_src;
        logic [ALUCTL_W-1:0] alu_control;
        logic [XLEN-1:0]     rd1;
        logic [XLEN-1:0]     rd2;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     ext_imm;
        logic [XLEN-1:0]     pc_plus4;
        logic [REG_AW-1:0]   rs1;
        logic [REG_AW-1:0]   rs2;
        logic [REG_AW-1:0]   rd;
    } e_slot_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    e_slot_t          d_slot;
    e_slot_t          e_d, e_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
    logic             stall_inc, bubble_inc;

    // Side-effect bits are gated by ValidD so an empty decode slot can never write state.
    always_comb begin
        d_slot             = '0;
        d_slot.valid       = ValidD;
        d_slot.reg_write   = RegWriteD & ValidD;
        d_slot.mem_write   = MemWriteD & ValidD;
        d_slot.jump        = JumpD & ValidD;
        d_slot.branch      = BranchD & ValidD;
        d_slot.alu_src     = ALUSrcD;
        d_slot.result_src  = ResultSrcD;
        d_slot.alu_control = ALUControlD;
        d_slot.rd1         = RD1D;
        d_slot.rd2         = RD2D;
        d_slot.pc          = PCD;
        d_slot.ext_imm     = ExtImmD;
        d_slot.pc_plus4    = PCPlus4D;
        d_slot.rs1         = RS1D;
        d_slot.rs2         = RS2D;
        d_slot.rd          = RDD;
    end

    // Flush zeroes every field, register indices included, so nothing forwards from a bubble.
    always_comb begin
        e_d = e_q;
        if (FlushE) begin
            e_d = '0;
        end else if (!StallE) begin
            e_d = d_slot;
        end
    end

    assign stall_inc  = StallE & ~FlushE;
    assign bubble_inc = FlushE | (~StallE & ~ValidD);

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (CntClr) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            if (bubble_inc && (bubble_cnt_q != CNT_MAX)) begin
                bubble_cnt_d = bubble_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q          <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            e_q          <= e_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ValidE      = e_q.valid;
    assign RegWriteE   = e_q.reg_write;
    assign MemWriteE   = e_q.mem_write;
    assign JumpE       = e_q.jump;
    assign BranchE     = e_q.branch;
    assign ALUSrcE     = e_q.alu_src;
    assign ResultSrcE  = e_q.result_src;
    assign ALUControlE = e_q.alu_control;
    assign RD1E        = e_q.rd1;
    assign RD2E        = e_q.rd2;
    assign PCE         = e_q.pc;
    assign ExtImmE     = e_q.ext_imm;
    assign PCPlus4E    = e_q.pc_plus4;
    assign RS1E        = e_q.rs1;
    assign RS2E        = e_q.rs2;
    assign RDE         = e_q.rd;
    assign StallCount  = stall_cnt_q;
    assign BubbleCount = bubble_cnt_q;

endmodule
